ibex_debug_req_ctrl: RTL and testbench

Synthesizable debug-request and fetch-enable controller: the driving end of the core's `debug_req` / `fetch_enable` control path. It accepts debug-session requests over a valid/ready handshake and asserts `debug_req` after a programmable delay. It then tracks debug entry and `dret` exit, and gates fetch on a major alert. It sits between an SoC/bench stimulus source and the `ibex_top` debug/fetch inputs.

---
 rtl/ibex_debug_req_ctrl.sv | 147 ++++++++++++++
 tb/tb_ibex_debug_req_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_debug_req_ctrl.sv
// Debug-request / fetch-enable controller driving the core's debug_req and fetch_enable inputs.
// Define IBEX_DBG_REQ_TIMEOUT_EN to build the REQ-state entry timeout.
module ibex_debug_req_ctrl #(
    parameter int unsigned CooldownCycles = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [7:0]  req_delay_i,
    output logic        req_ready_o,
    input  logic        debug_mode_i,
    input  logic        dret_i,
    input  logic        alert_major_i,
    output logic        debug_req_o,
    output logic [3:0]  fetch_enable_o,
    output logic [15:0] session_cnt_o,
    output logic        timeout_o,
    output logic        halted_o
);

    localparam logic [3:0]  IbexMuBiOn   = 4'b0101;
    localparam logic [3:0]  IbexMuBiOff  = 4'b1010;
    localparam logic [15:0] CooldownInit = 16'(CooldownCycles);
    localparam logic [15:0] TimeoutLast  = 16'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StReq,
        StInDebug,
        StCooldown,
        StHalt
    } state_t;

    state_t      state_q;
    logic [7:0]  dly_q;
    logic [15:0] cd_q;
    logic [15:0] session_q;
    logic        debug_req_q;
    logic [3:0]  fetch_q;
    logic        halted_q;
`ifdef IBEX_DBG_REQ_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        timeout_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            dly_q       <= 8'd0;
            cd_q        <= 16'd0;
            session_q   <= 16'd0;
            debug_req_q <= 1'b0;
            fetch_q     <= IbexMuBiOn;
            halted_q    <= 1'b0;
`ifdef IBEX_DBG_REQ_TIMEOUT_EN
            tmo_q       <= 16'd0;
            timeout_q   <= 1'b0;
`endif
        end else if (alert_major_i) begin
            // Alert outranks every other transition, including a same-cycle dret.
            state_q     <= StHalt;
            halted_q    <= 1'b1;
            fetch_q     <= IbexMuBiOff;
            debug_req_q <= 1'b0;
        end else begin
`ifdef IBEX_DBG_REQ_TIMEOUT_EN
            tmo_q <= 16'd0;
`endif
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        dly_q <= req_delay_i;
                        if (req_delay_i == 8'd0) begin
                            state_q     <= StReq;
                            debug_req_q <= 1'b1;
                        end else begin
                            state_q <= StDelay;
                        end
                    end
                end
                StDelay: begin
                    if (dly_q == 8'd1) begin
                        state_q     <= StReq;
                        debug_req_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - 8'd1;
                    end
                end
                StReq: begin
                    if (debug_mode_i) begin
                        state_q     <= StInDebug;
                        debug_req_q <= 1'b0;
                    end
`ifdef IBEX_DBG_REQ_TIMEOUT_EN
                    else if (tmo_q == TimeoutLast) begin
                        state_q     <= StIdle;
                        debug_req_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
`endif
                end
                StInDebug: begin
                    if (dret_i) begin
                        session_q <= session_q + 16'd1;
                        cd_q      <= CooldownInit;
                        state_q   <= StCooldown;
                    end
                end
                StCooldown: begin
                    if (cd_q <= 16'd1) begin
                        state_q <= StIdle;
                    end else begin
                        cd_q <= cd_q - 16'd1;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q     <= StHalt;
                    halted_q    <= 1'b1;
                    fetch_q     <= IbexMuBiOff;
                    debug_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o    = (state_q == StIdle);
    assign debug_req_o    = debug_req_q;
    assign fetch_enable_o = fetch_q;
    assign session_cnt_o  = session_q;
    assign halted_o       = halted_q;

`ifdef IBEX_DBG_REQ_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutLast;
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_debug_req_ctrl.sv
// Directed self-checking bench for ibex_debug_req_ctrl (CooldownCycles=4, TimeoutCycles=16).
module tb_ibex_debug_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_delay;
    logic        req_ready;
    logic        debug_mode;
    logic        dret;
    logic        alert_major;
    logic        debug_req;
    logic [3:0]  fetch_enable;
    logic [15:0] session_cnt;
    logic        timeout;
    logic        halted;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] MuBiOn  = 32'h5;
    localparam logic [31:0] MuBiOff = 32'hA;

    ibex_debug_req_ctrl #(
        .CooldownCycles(4),
        .TimeoutCycles (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_delay_i   (req_delay),
        .req_ready_o   (req_ready),
        .debug_mode_i  (debug_mode),
        .dret_i        (dret),
        .alert_major_i (alert_major),
        .debug_req_o   (debug_req),
        .fetch_enable_o(fetch_enable),
        .session_cnt_o (session_cnt),
        .timeout_o     (timeout),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_dreq"}, 32'(debug_req), 32'd0);
        check({tag, "_fetch"}, 32'(fetch_enable), MuBiOn);
        check({tag, "_cnt"}, 32'(session_cnt), 32'd0);
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
        check({tag, "_halt"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_delay = 8'd0;
        debug_mode = 1'b0; dret = 1'b0; alert_major = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("rst");

        // delay 3: debug_req rises on the 3rd edge after acceptance
        req_valid = 1'b1; req_delay = 8'd3;
        step();
        req_valid = 1'b0;
        check("d3_ready_acc", 32'(req_ready), 32'd0);
        check("d3_dreq_t0", 32'(debug_req), 32'd0);
        step();
        check("d3_dreq_t1", 32'(debug_req), 32'd0);
        step();
        check("d3_dreq_t2", 32'(debug_req), 32'd0);
        step();
        check("d3_dreq_t3", 32'(debug_req), 32'd1);
        step();
        check("d3_dreq_t4", 32'(debug_req), 32'd1);
        step();
        check("d3_dreq_t5", 32'(debug_req), 32'd1);
        check("d3_ready_req", 32'(req_ready), 32'd0);
        debug_mode = 1'b1;
        step();
        check("d3_dreq_drop", 32'(debug_req), 32'd0);
        check("d3_ready_dbg", 32'(req_ready), 32'd0);

        // dret ends the session; a request held through cooldown is taken on first IDLE edge
        dret = 1'b1;
        step();
        dret = 1'b0; debug_mode = 1'b0;
        req_valid = 1'b1; req_delay = 8'd0;
        check("sess_cnt1", 32'(session_cnt), 32'd1);
        check("cd_ready_0", 32'(req_ready), 32'd0);
        step();
        check("cd_ready_1", 32'(req_ready), 32'd0);
        step();
        check("cd_ready_2", 32'(req_ready), 32'd0);
        step();
        check("cd_ready_3", 32'(req_ready), 32'd0);
        step();
        check("cd_ready_4", 32'(req_ready), 32'd1);
        check("cd_dreq_idle", 32'(debug_req), 32'd0);
        step();
        req_valid = 1'b0;
        check("d0_dreq", 32'(debug_req), 32'd1);
        check("d0_ready", 32'(req_ready), 32'd0);

        // dret outside IN_DEBUG is ignored
        dret = 1'b1;
        step();
        dret = 1'b0;
        check("dret_ign_cnt", 32'(session_cnt), 32'd1);
        check("dret_ign_dreq", 32'(debug_req), 32'd1);
        debug_mode = 1'b1;
        step();
        check("d0_dreq_drop", 32'(debug_req), 32'd0);

        // alert together with dret: halt wins, no count
        alert_major = 1'b1; dret = 1'b1;
        step();
        alert_major = 1'b0; dret = 1'b0; debug_mode = 1'b0;
        check("alert_halt", 32'(halted), 32'd1);
        check("alert_fetch", 32'(fetch_enable), MuBiOff);
        check("alert_cnt", 32'(session_cnt), 32'd1);
        check("alert_dreq", 32'(debug_req), 32'd0);
        req_valid = 1'b1; req_delay = 8'd0;
        repeat (3) step();
        req_valid = 1'b0;
        check("halt_ready", 32'(req_ready), 32'd0);
        check("halt_dreq", 32'(debug_req), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst2");

        // session counter wraps
        force dut.session_q = 16'hFFFF;
        step();
        release dut.session_q;
        check("wrap_pre", 32'(session_cnt), 32'hFFFF);
        req_valid = 1'b1; req_delay = 8'd0;
        step();
        req_valid = 1'b0;
        check("wrap_dreq", 32'(debug_req), 32'd1);
        debug_mode = 1'b1;
        step();
        dret = 1'b1;
        step();
        dret = 1'b0; debug_mode = 1'b0;
        check("wrap_cnt", 32'(session_cnt), 32'd0);
        repeat (4) step();
        check("wrap_ready", 32'(req_ready), 32'd1);

        // entry timeout (or indefinite wait without the timeout build)
        req_valid = 1'b1; req_delay = 8'd0;
        step();
        req_valid = 1'b0;
        check("tmo_dreq0", 32'(debug_req), 32'd1);
`ifdef IBEX_DBG_REQ_TIMEOUT_EN
        repeat (15) step();
        check("tmo_dreq15", 32'(debug_req), 32'd1);
        check("tmo_flag15", 32'(timeout), 32'd0);
        step();
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_dreq", 32'(debug_req), 32'd0);
        check("tmo_idle", 32'(req_ready), 32'd1);
        check("tmo_cnt", 32'(session_cnt), 32'd0);
`else
        repeat (1000) step();
        check("wait_dreq", 32'(debug_req), 32'd1);
        check("wait_tmo", 32'(timeout), 32'd0);
        check("wait_ready", 32'(req_ready), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
